// File: rtl/joy_serial_scanner.sv
// Scans the 74HC165-style chain carrying both JAMMA player inputs and commits
// debounced, active-low joystick words atomically once per matching frame.
module joy_serial_scanner #(
  parameter int unsigned CLK_DIV      = 64,
  parameter int unsigned MATCH_FRAMES = 2
) (
  input  logic        clk12,
  input  logic        reset,
  input  logic        scan_en,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_valid
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MatchW = $clog2(MATCH_FRAMES + 1);
  localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(MATCH_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StGap, StShift, StCommit} state_e;

  state_e              state_q;
  logic [DivW-1:0]     div_q;
  logic [4:0]          bit_q;
  logic [23:0]         raw_q;
  logic [23:0]         prev_q;
  logic [MatchW-1:0]   match_q;

  logic                wrap;
  logic                rise;
  logic                fall;
  logic [MatchW-1:0]   match_d;
  logic [23:0]         mapped;
  logic                commit_ok;

  assign wrap = (div_q == DivLast);
  assign rise = wrap & ~joy_clk;
  assign fall = wrap & joy_clk;

  // Chain order -> {joystick2, joystick1}; chain bit k is raw_q[k].
  function automatic logic [23:0] map_bits(input logic [23:0] r);
    logic [11:0] j1;
    logic [11:0] j2;
    j1 = {r[21], r[20], r[22], r[0], r[23], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
    j2 = {r[17], r[16], r[18], r[8], r[19], r[9], r[10], r[11], r[12], r[13], r[14], r[15]};
    return {j2, j1};
  endfunction

  always_comb begin
    match_d = '0;
    if (raw_q == prev_q) begin
      match_d = (match_q == MatchMax) ? match_q : match_q + MatchW'(1);
    end
    mapped    = map_bits(raw_q);
    commit_ok = (match_d == MatchMax) && (mapped != {joystick2, joystick1});
  end

  // joy_clk free-runs regardless of FSM state.
  always_ff @(posedge clk12) begin
    if (reset) begin
      div_q   <= '0;
      joy_clk <= 1'b0;
    end else if (wrap) begin
      div_q   <= '0;
      joy_clk <= ~joy_clk;
    end else begin
      div_q   <= div_q + DivW'(1);
    end
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      state_q     <= StIdle;
      joy_load    <= 1'b1;
      bit_q       <= '0;
      raw_q       <= '1;
      prev_q      <= '1;
      match_q     <= '0;
      joystick1   <= 12'hFFF;
      joystick2   <= 12'hFFF;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          joy_load <= 1'b1;
          if (scan_en && fall) begin
            state_q  <= StLoad;
            joy_load <= 1'b0;
          end
        end
        StLoad: begin
          if (fall) begin
            state_q  <= StGap;
            joy_load <= 1'b1;
          end
        end
        StGap: begin
          if (fall) begin
            state_q <= StShift;
            bit_q   <= '0;
          end
        end
        StShift: begin
          if (rise) begin
            raw_q[bit_q] <= joy_data;
          end
          if (fall) begin
            if (bit_q == 5'd23) begin
              state_q <= StCommit;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end
        StCommit: begin
          match_q <= match_d;
          prev_q  <= raw_q;
          if (commit_ok) begin
            joystick2   <= mapped[23:12];
            joystick1   <= mapped[11:0];
            frame_valid <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
